// File: rtl/wb_step_reporter.sv
// wb_step_reporter: Wishbone slave that queues firmware {status,step} progress
// words in a small FIFO. Each word is shown on the user io pads for a minimum
// number of clocks, so a slow pad-level monitor never misses a step.

module wb_step_reporter #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 16,
    parameter int          STEP_LSB    = 20,
    parameter int          STATUS_LSB  = 36
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CNT_SHOW = (CNT_W < 3) ? CNT_W : 3;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [HOLD_W-1:0] hold_cnt;

    logic [5:0] disp_step;
    logic [1:0] disp_status;
    logic [5:0] shadow_step;
    logic [1:0] shadow_status;

    logic        addr_hit;
    logic        report_sel;
    logic        stat_sel;
    logic        bus_req;
    logic        fifo_full;
    logic        report_wr;
    logic        accept;
    logic        push;
    logic        pop;
    logic        busy;
    logic [5:0]  push_step;
    logic [1:0]  push_status;
    logic [31:0] stat_word;
    logic [31:0] report_word;
    logic        unused_bits;

    // A request is only considered while no ack is showing, which forces the
    // idle cycle between back-to-back acks. Full uses the registered count, so
    // a pop in the same cycle never lets a blocked push through early.
    assign addr_hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign report_sel  = (wbs_adr_i[3:2] == 2'b00);
    assign stat_sel    = (wbs_adr_i[3:2] == 2'b01);
    assign bus_req     = wbs_cyc_i && wbs_stb_i && addr_hit && !wbs_ack_o;
    assign fifo_full   = (count == FULL_COUNT);
    assign report_wr   = bus_req && wbs_we_i && report_sel;
    assign accept      = bus_req && !(report_wr && fifo_full);
    assign push        = accept && report_wr;
    assign busy        = (state_q != ST_IDLE);

    // Fields whose byte lane is not selected inherit the last pushed entry.
    assign push_step   = wbs_sel_i[0] ? wbs_dat_i[5:0] : shadow_step;
    assign push_status = wbs_sel_i[1] ? wbs_dat_i[9:8] : shadow_status;

    assign report_word = {22'b0, disp_status, 2'b00, disp_step};

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:10], wbs_dat_i[7:6], wbs_adr_i[1:0]};

    // Status register image: fifo count, busy flag and full flag.
    always_comb begin
        stat_word = '0;
        stat_word[CNT_SHOW-1:0] = count[CNT_SHOW-1:0];
        stat_word[8] = busy;
        stat_word[9] = fifo_full;
    end

    // Display sequencer: wait for data, pop one entry, then hold it on the pads.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pop     = (count != '0);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d = (count != '0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold timer runs only in HOLD and restarts from zero for every entry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_cnt <= '0;
        end else if (state_q == ST_HOLD) begin
            hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {push_status, push_step};
        end
    end

    // Shadow of the last pushed entry, used for field merging.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shadow_step   <= 6'd0;
            shadow_status <= 2'b00;
        end else if (push) begin
            shadow_step   <= push_step;
            shadow_status <= push_status;
        end
    end

    // Display registers load the popped head and otherwise keep their value.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            disp_step   <= 6'd0;
            disp_status <= 2'b01;
        end else if (pop) begin
            disp_step   <= fifo_mem[rd_ptr][5:0];
            disp_status <= fifo_mem[rd_ptr][7:6];
        end
    end

    // Bus response: one-cycle ack, read data only alongside a read ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= accept;
            if (accept && !wbs_we_i) begin
                if (report_sel) begin
                    wbs_dat_o <= report_word;
                end else if (stat_sel) begin
                    wbs_dat_o <= stat_word;
                end else begin
                    wbs_dat_o <= '0;
                end
            end else begin
                wbs_dat_o <= '0;
            end
        end
    end

    // Pad mapping: only the step and status bits are driven.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        io_out[STEP_LSB +: 6]   = disp_step;
        io_out[STATUS_LSB +: 2] = disp_status;
        io_oeb[STEP_LSB +: 6]   = 6'b0;
        io_oeb[STATUS_LSB +: 2] = 2'b0;
    end

endmodule

// File: tb/tb_wb_step_reporter.sv
// Directed self-checking bench for wb_step_reporter.

module tb_wb_step_reporter;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_i  = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mon_val = 8'h00;
    int         mon_len = 0;
    logic [7:0] log_val [$];
    int         log_len [$];

    wb_step_reporter dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Record every displayed {status,step} value and how many cycles it stayed.
    always @(negedge wb_clk_i) begin
        if ({io_out[37:36], io_out[25:20]} === mon_val) begin
            mon_len++;
        end else begin
            log_val.push_back(mon_val);
            log_len.push_back(mon_len);
            mon_val = {io_out[37:36], io_out[25:20]};
            mon_len = 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic busIdle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
    endtask

    // Bus write; returns the number of edges until the ack was seen.
    task automatic applyStimulus(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, output int waited);
        logic acked;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        waited = 0;
        acked  = 1'b0;
        while (!acked && waited < 100) begin
            @(posedge wb_clk_i);
            #1;
            waited++;
            acked = wbs_ack_o;
        end
        busIdle();
        checkOutput({tag, "_ack"}, acked, 1);
    endtask

    // Bus read; data is captured in the ack cycle.
    task automatic readRegister(input string tag, input logic [31:0] adr, output logic [31:0] data);
        logic acked;
        int   waited;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = adr;
        wbs_sel_i = 4'hF;
        waited = 0;
        acked  = 1'b0;
        data   = '0;
        while (!acked && waited < 100) begin
            @(posedge wb_clk_i);
            #1;
            waited++;
            acked = wbs_ack_o;
            data  = wbs_dat_o;
        end
        busIdle();
        checkOutput({tag, "_ack"}, acked, 1);
    endtask

    task automatic waitDisplay(input logic [7:0] want, input int limit, output logic found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(posedge wb_clk_i);
            #1;
            found = ({io_out[37:36], io_out[25:20]} == want);
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          waited;
        int          bad;
        int          base_idx;
        logic [31:0] rd;
        logic        found;

        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Test 1: reset values on the pads and bus.
        @(posedge wb_clk_i);
        #1;
        checkOutput("t1_io_out", io_out, 38'h10_0000_0000);
        checkOutput("t1_io_oeb", io_oeb, 38'h0F_FC0F_FFFF);
        checkOutput("t1_ack", wbs_ack_o, 0);
        checkOutput("t1_dat", wbs_dat_o, 0);

        // Test 2: single write, ack timing and three-cycle display latency.
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE;
        wbs_dat_i = 32'h0000_0005;
        wbs_sel_i = 4'b0011;
        @(posedge wb_clk_i);
        #1;
        checkOutput("t2_ack_n1", wbs_ack_o, 1);
        checkOutput("t2_io_n1", io_out[25:20], 0);
        busIdle();
        @(posedge wb_clk_i);
        #1;
        checkOutput("t2_ack_n2", wbs_ack_o, 0);
        checkOutput("t2_io_n2", io_out[25:20], 0);
        @(posedge wb_clk_i);
        #1;
        checkOutput("t2_io_n3", io_out, 38'h00_0050_0000);
        bad = 0;
        repeat (15) begin
            @(posedge wb_clk_i);
            #1;
            if (io_out !== 38'h00_0050_0000) bad++;
        end
        checkOutput("t2_stable", bad, 0);
        readRegister("t2_rd", BASE, rd);
        checkOutput("t2_report_rd", rd, 32'h0000_0005);

        // Test 4: unselected status lane inherits the previous entry.
        applyStimulus("t4_w1", BASE, 32'h0000_0203, 4'b0011, waited);
        applyStimulus("t4_w2", BASE, 32'h0000_0007, 4'b0001, waited);
        waitDisplay(8'h87, 80, found);
        checkOutput("t4_merged_seen", found, 1);
        checkOutput("t4_status", io_out[37:36], 2'b10);

        // Test 3: fill the FIFO while step 7 is held; the fifth write waits for a pop.
        log_val.delete();
        log_len.delete();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus($sformatf("t3_w%0d", k), BASE, 32'(k), 4'b0011, waited);
        end
        readRegister("t3_rd", BASE + 32'h4, rd);
        checkOutput("t3_stat_full", rd, 32'h0000_0304);
        applyStimulus("t3_w5", BASE, 32'h0000_0005, 4'b0011, waited);
        checkOutput("t3_w5_heldoff", waited > 2, 1);
        waitDisplay(8'h05, 200, found);
        checkOutput("t3_step5_seen", found, 1);
        repeat (20) @(posedge wb_clk_i);
        #1;
        base_idx = -1;
        foreach (log_val[i]) begin
            if (base_idx < 0 && log_val[i] == 8'h01) base_idx = i;
        end
        checkOutput("t3_step1_seen", base_idx >= 0, 1);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] got_v;
            int         got_l;
            if (base_idx >= 0 && base_idx + k < log_val.size()) begin
                got_v = log_val[base_idx + k];
                got_l = log_len[base_idx + k];
            end else begin
                got_v = 8'hFF;
                got_l = 0;
            end
            checkOutput($sformatf("t3_order%0d", k + 1), got_v, 8'(k + 1));
            checkOutput($sformatf("t3_hold%0d", k + 1), got_l >= 16, 1);
        end
        checkOutput("t3_last_val", mon_val, 8'h05);
        checkOutput("t3_last_hold", mon_len >= 16, 1);

        // Test 6a: STAT with two entries queued behind the displayed one.
        applyStimulus("t6_w1", BASE, 32'h0000_030A, 4'b0011, waited);
        applyStimulus("t6_w2", BASE, 32'h0000_030B, 4'b0011, waited);
        applyStimulus("t6_w3", BASE, 32'h0000_030C, 4'b0011, waited);
        readRegister("t6_rd", BASE + 32'h4, rd);
        checkOutput("t6_stat_two", rd, 32'h0000_0102);

        // Test 5: reset in HOLD with three entries queued.
        applyStimulus("t5_w4", BASE, 32'h0000_030D, 4'b0011, waited);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        checkOutput("t5_io_reset", io_out, 38'h10_0000_0000);
        checkOutput("t5_ack_reset", wbs_ack_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        readRegister("t5_rd_stat", BASE + 32'h4, rd);
        checkOutput("t5_stat_zero", rd, 32'h0);
        readRegister("t5_rd_rep", BASE, rd);
        checkOutput("t5_report", rd, 32'h0000_0100);
        bad = 0;
        repeat (40) begin
            @(posedge wb_clk_i);
            #1;
            if (io_out !== 38'h10_0000_0000) bad++;
        end
        checkOutput("t5_no_stale", bad, 0);

        // Test 6b: an address outside the slave window is never acked.
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE + 32'h100;
        bad = 0;
        waited = 0;
        repeat (20) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o !== 1'b0) bad++;
            if (wbs_dat_o !== 32'h0) waited++;
        end
        busIdle();
        checkOutput("t6_no_ack", bad, 0);
        checkOutput("t6_dat_zero", waited, 0);

        // Writes to STAT are acknowledged but change nothing.
        applyStimulus("t6_stat_wr", BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, waited);
        readRegister("t6_rd2", BASE + 32'h4, rd);
        checkOutput("t6_stat_unchanged", rd, 32'h0);
        checkOutput("t6_io_unchanged", io_out, 38'h10_0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
